// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-through no-write-allocate data cache in front of dm
module dcache_ctrl #(
    parameter int LINES      = 16,
    parameter int ADDR_W     = 12,
    parameter int WRITE_HOLD = 3
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [31:0]       i_cpu_wdata,
    output logic [31:0]       o_cpu_rdata,
    output logic              o_cpu_stall,
    output logic              o_dm_enable,
    output logic              o_dm_read,
    output logic              o_dm_write,
    output logic [ADDR_W-1:0] o_dm_address,
    output logic [31:0]       o_dm_in,
    input  logic [31:0]       i_dm_out,
    input  logic              i_dm_ready
);
    localparam int IW = $clog2(LINES);
    localparam int TW = ADDR_W - 6 - IW;
    localparam int HW = $clog2(WRITE_HOLD + 1);
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_FILL_REQ = 3'd1;
    localparam logic [2:0] S_FILL     = 3'd2;
    localparam logic [2:0] S_WR_ISSUE = 3'd3;
    localparam logic [2:0] S_WR_DRAIN = 3'd4;
    localparam logic [2:0] S_WR_DONE  = 3'd5;
    logic [2:0]        r_state;
    logic [LINES-1:0]  r_valid;
    logic [TW-1:0]     r_tag [LINES];
    logic [31:0]       r_data [LINES*16];
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_cnt;
    logic [HW-1:0]     r_hold;
    logic              r_dm_en, r_dm_rd, r_dm_wr;
    logic [ADDR_W-1:0] r_dm_addr;
    logic [31:0]       r_dm_in;
    logic [IW-1:0]     w_idx, w_fill_idx;
    logic [TW-1:0]     w_tag;
    logic [3:0]        w_off;
    logic              w_idle, w_hit, w_ld_hit, w_unused;
    assign w_idx        = i_cpu_addr[6+:IW];
    assign w_tag        = i_cpu_addr[6+IW+:TW];
    assign w_off        = i_cpu_addr[5:2];
    assign w_fill_idx   = r_addr[6+:IW];
    assign w_idle       = r_state == S_IDLE;
    assign w_hit        = r_valid[w_idx] && r_tag[w_idx] == w_tag;
    assign w_ld_hit     = w_idle && i_cpu_req && !i_cpu_we && w_hit && !i_rst;
    assign w_unused     = ^i_cpu_addr[1:0];
    assign o_cpu_rdata  = w_ld_hit ? r_data[{w_idx, w_off}] : '0;
    assign o_cpu_stall  = i_rst || !(w_ld_hit || r_state == S_WR_DONE);
    assign o_dm_enable  = r_dm_en;
    assign o_dm_read    = r_dm_rd;
    assign o_dm_write   = r_dm_wr;
    assign o_dm_address = r_dm_addr;
    assign o_dm_in      = r_dm_in;
    // data array: burst words during fill, store hits update the cached word in place
    always_ff @(posedge i_clk) begin
        if (r_state == S_FILL && i_dm_ready)
            r_data[{w_fill_idx, r_cnt}] <= i_dm_out;
        else if (w_idle && i_cpu_req && i_cpu_we && w_hit)
            r_data[{w_idx, w_off}] <= i_cpu_wdata;
    end
    // control FSM; dm outputs are registered so they are high only in FILL_REQ/WR_ISSUE
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_valid   <= '0;
            for (int i = 0; i < LINES; i++) r_tag[i] <= '0;
            r_addr    <= '0;
            r_cnt     <= '0;
            r_hold    <= '0;
            r_dm_en   <= 1'b0;
            r_dm_rd   <= 1'b0;
            r_dm_wr   <= 1'b0;
            r_dm_addr <= '0;
            r_dm_in   <= '0;
        end else begin
            r_dm_en   <= 1'b0;
            r_dm_rd   <= 1'b0;
            r_dm_wr   <= 1'b0;
            r_dm_addr <= '0;
            r_dm_in   <= '0;
            case (r_state)
                S_IDLE: begin
                    if (i_cpu_req && i_cpu_we) begin
                        r_addr    <= {i_cpu_addr[ADDR_W-1:2], 2'b00};
                        r_dm_en   <= 1'b1;
                        r_dm_wr   <= 1'b1;
                        r_dm_addr <= {i_cpu_addr[ADDR_W-1:2], 2'b00};
                        r_dm_in   <= i_cpu_wdata;
                        r_state   <= S_WR_ISSUE;
                    end else if (i_cpu_req && !w_hit) begin
                        r_addr    <= {i_cpu_addr[ADDR_W-1:6], 6'd0};
                        r_dm_en   <= 1'b1;
                        r_dm_rd   <= 1'b1;
                        r_dm_addr <= {i_cpu_addr[ADDR_W-1:6], 6'd0};
                        r_state   <= S_FILL_REQ;
                    end
                end
                S_FILL_REQ: begin
                    r_valid[w_fill_idx] <= 1'b0;
                    r_cnt               <= '0;
                    r_state             <= S_FILL;
                end
                S_FILL: begin
                    if (i_dm_ready) begin
                        r_cnt <= r_cnt + 4'd1;
                        if (r_cnt == 4'd15) begin
                            r_valid[w_fill_idx] <= 1'b1;
                            r_tag[w_fill_idx]   <= r_addr[6+IW+:TW];
                            r_state             <= S_IDLE;
                        end
                    end
                end
                S_WR_ISSUE: begin
                    r_hold  <= HW'(WRITE_HOLD - 1);
                    r_state <= S_WR_DRAIN;
                end
                S_WR_DRAIN: begin
                    if (r_hold == '0) r_state <= S_WR_DONE;
                    else r_hold <= r_hold - 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: scoreboard bench for dcache_ctrl with a streaming dm model
module tb_dcache_ctrl;
    localparam int WRITE_HOLD = 3;
    logic        clk = 1'b0, rst = 1'b1, req = 1'b0, we = 1'b0;
    logic [11:0] addr = '0;
    logic [31:0] wdata = '0, dm_out = '0;
    logic        dm_ready = 1'b0;
    logic [31:0] rdata, dm_in;
    logic        stall, dm_enable, dm_read, dm_write;
    logic [11:0] dm_addr;
    logic [31:0] gap_mask = '0;
    logic [31:0] exp_mem [1024];
    logic [31:0] exp_q [$];
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    dcache_ctrl dut (
        .i_clk(clk), .i_rst(rst), .i_cpu_req(req), .i_cpu_we(we),
        .i_cpu_addr(addr), .i_cpu_wdata(wdata), .o_cpu_rdata(rdata),
        .o_cpu_stall(stall), .o_dm_enable(dm_enable), .o_dm_read(dm_read),
        .o_dm_write(dm_write), .o_dm_address(dm_addr), .o_dm_in(dm_in),
        .i_dm_out(dm_out), .i_dm_ready(dm_ready)
    );

    // dm model: captures writes, streams a 16-word burst after a line read, ignores reset
    logic [31:0] mem [1024];
    int          left = 0, bcyc = 0;
    logic [9:0]  bbase = '0;
    bit          mem_init = 0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 1024; i++) mem[i] = 32'hF0 + i;
            mem_init = 1;
        end
        #1;
        if (left > 0) begin
            if (gap_mask[bcyc]) dm_ready = 1'b0;
            else begin
                dm_ready = 1'b1;
                dm_out = mem[bbase + 10'(16 - left)];
                left--;
            end
            bcyc++;
        end else dm_ready = 1'b0;
        if (dm_enable && dm_write) mem[dm_addr[11:2]] = dm_in;
        if (dm_enable && dm_read) begin
            left = 16;
            bcyc = 0;
            bbase = dm_addr[11:2];
        end
    end

    task automatic do_load(input logic [11:0] a, input int exp_stall, input string nm);
        int cyc = 0, nrd = 0, rcyc = -1;
        logic [11:0] ra = '0;
        logic [31:0] e;
        exp_q.push_back(exp_mem[a[11:2]]);
        @(posedge clk); #1;
        req = 1'b1; we = 1'b0; addr = a;
        forever begin
            @(negedge clk);
            if (dm_read && dm_enable) begin nrd++; ra = dm_addr; rcyc = cyc; end
            if (!stall) break;
            checks++;
            if (rdata !== 32'h0) begin errors++; $display("FAIL %s rdata_while_stalled got %h want 0", nm, rdata); end
            cyc++;
            if (cyc > 200) begin errors++; $display("FAIL %s timeout stall never dropped", nm); break; end
        end
        e = exp_q.pop_front();
        checks++;
        if (rdata !== e) begin errors++; $display("FAIL %s rdata got %h want %h", nm, rdata, e); end
        checks++;
        if (cyc != exp_stall) begin errors++; $display("FAIL %s stall_cycles got %0d want %0d", nm, cyc, exp_stall); end
        checks++;
        if (nrd != (exp_stall > 0 ? 1 : 0)) begin errors++; $display("FAIL %s dm_read_pulses got %0d want %0d", nm, nrd, exp_stall > 0 ? 1 : 0); end
        if (exp_stall > 0) begin
            checks++;
            if (ra !== {a[11:6], 6'd0} || rcyc != 1) begin
                errors++; $display("FAIL %s fill_req addr %h cyc %0d want %h cyc 1", nm, ra, rcyc, {a[11:6], 6'd0});
            end
        end
    endtask

    task automatic do_store(input logic [11:0] a, input logic [31:0] d, input string nm);
        int cyc = 0, nwr = 0, wcyc = -1;
        logic [11:0] wa = '0;
        logic [31:0] wd = '0;
        @(posedge clk); #1;
        req = 1'b1; we = 1'b1; addr = a; wdata = d;
        forever begin
            @(negedge clk);
            if (dm_write && dm_enable) begin nwr++; wcyc = cyc; wa = dm_addr; wd = dm_in; end
            if (!stall) break;
            cyc++;
            if (cyc > 50) begin errors++; $display("FAIL %s timeout store never consumed", nm); break; end
        end
        exp_mem[a[11:2]] = d;
        checks++;
        if (cyc != WRITE_HOLD + 2) begin errors++; $display("FAIL %s stall_cycles got %0d want %0d", nm, cyc, WRITE_HOLD + 2); end
        checks++;
        if (nwr != 1 || wcyc != 1) begin errors++; $display("FAIL %s dm_write pulses %0d at cyc %0d want 1 at 1", nm, nwr, wcyc); end
        checks++;
        if (wa !== a || wd !== d) begin errors++; $display("FAIL %s dm_write addr/data %h/%h want %h/%h", nm, wa, wd, a, d); end
    endtask

    task automatic go_idle(input int n);
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    task automatic test_reset();
        req = 1'b1; addr = 12'h040;
        @(negedge clk);
        checks++;
        if (stall !== 1'b1 || rdata !== 32'h0) begin errors++; $display("FAIL reset stall/rdata got %b/%h want 1/0", stall, rdata); end
        checks++;
        if ({dm_enable, dm_read, dm_write} !== 3'b000 || dm_addr !== 12'h0 || dm_in !== 32'h0) begin
            errors++; $display("FAIL reset dm outputs en%b rd%b wr%b a%h d%h want all 0", dm_enable, dm_read, dm_write, dm_addr, dm_in);
        end
        req = 1'b0;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_miss_fill();
        do_load(12'h040, 18, "miss_040");
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i < 16; i++) do_load(12'h040 + 12'(4 * i), 0, "hit_b2b");
        go_idle(1);
    endtask

    task automatic test_store_hit();
        do_store(12'h048, 32'hDEADBEEF, "store_hit");
        do_load(12'h048, 0, "load_after_store_hit");
        go_idle(1);
    endtask

    task automatic test_store_miss();
        do_store(12'h480, 32'hCAFEF00D, "store_miss");
        do_load(12'h480, 18, "load_after_store_miss");
        do_load(12'h484, 0, "hit_480_line");
        go_idle(1);
    endtask

    task automatic test_gap_fill();
        gap_mask = 32'h0000_0488;
        do_load(12'h100, 21, "gap_fill");
        gap_mask = '0;
        for (int i = 0; i < 16; i++) do_load(12'h100 + 12'(4 * i), 0, "gap_words");
        go_idle(1);
    endtask

    task automatic test_reset_mid_fill();
        int n = 0, cyc = 0;
        @(posedge clk); #1;
        req = 1'b1; we = 1'b0; addr = 12'h0C0;
        while (n < 5 && cyc < 60) begin
            @(negedge clk);
            if (dm_ready) n++;
            cyc++;
        end
        checks++;
        if (n != 5) begin errors++; $display("FAIL midfill_ready_count got %0d want 5", n); end
        @(posedge clk); #2;
        rst = 1'b1; req = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b1 || {dm_enable, dm_read, dm_write} !== 3'b000) begin
            errors++; $display("FAIL midfill_reset stall %b dm en%b rd%b wr%b want 1 000", stall, dm_enable, dm_read, dm_write);
        end
        @(negedge clk); @(negedge clk); rst = 1'b0;
        go_idle(20);
        do_load(12'h0C0, 18, "refetch_after_reset");
        do_load(12'h0FC, 0, "refetch_last_word");
        go_idle(1);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) exp_mem[i] = 32'hF0 + i;
        test_reset();
        test_miss_fill();
        test_back_to_back();
        test_store_hit();
        test_store_miss();
        test_gap_fill();
        test_reset_mid_fill();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-through, no-write-allocate data cache between the CPU load/store port and the `dm` data memory. It turns CPU word accesses into `dm` transactions. Read misses fetch a whole 16-word (64-byte) line with one single-cycle read request and then absorb the burst that `dm` streams back under `DM_ready`. Writes go straight through to `dm`, and the cache holds the CPU stalled for a fixed drain time.

## Interface
- LINES, 16: number of cache lines; index width = log2(LINES) = 4.
- ADDR_W, 12: byte-address width on both the CPU and `dm` sides.
- WRITE_HOLD, 3: number of drain cycles after a write issue; must be ≥ the `dm` wait-state depth + 1.

- clock  in  1  single clock, all state on posedge.
- reset  in  1  asynchronous, active-high.
- cpu_req  in  1  CPU access request, held until accepted.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  ADDR_W  byte address; bits [1:0] are ignored.
- cpu_wdata  in  32  store data.
- cpu_rdata  out  32  load data; valid while cpu_req & !cpu_we & !cpu_stall.
- cpu_stall  out  1  the request is consumed on a posedge where cpu_req=1 and cpu_stall=0.
- DM_enable  out  1  `dm` enable.
- DM_read  out  1  `dm` line-read request.
- DM_write  out  1  `dm` word write.
- DM_address  out  ADDR_W  `dm` byte address.
- DM_in  out  32  `dm` write data.
- DM_out  in  32  `dm` read data.
- DM_ready  in  1  `dm` read-data-valid strobe.

## Operation
- Address split: offset [5:2] is the word within the line; index [9:6]; tag [11:10].
- Storage:
  - data array of LINES×16×32 bits, not reset;
  - tag array of LINES×2 bits;
  - valid bits, LINES×1, cleared by reset.
- Hit is `valid[index] && tag[index]==tag(cpu_addr)`.
- FSM states: IDLE, FILL_REQ, FILL, WR_ISSUE, WR_DRAIN, WR_DONE.
- IDLE:
  - Load hit: cpu_stall=0 and cpu_rdata = data[index][offset], combinational.
  - Load miss: cpu_stall=1; latch the line base (cpu_addr with [5:0]=0); go to FILL_REQ.
  - Store, hit or miss: cpu_stall=1; latch address and data; if hit, write the word into the data array on this edge; go to WR_ISSUE.
  - No request: stay in IDLE.
- FILL_REQ (1 cycle):
  - Drive DM_enable=1, DM_read=1, DM_address=line base.
  - Clear valid[index] on the edge; word counter=0; go to FILL.
- FILL:
  - cpu_stall=1; all DM_* outputs are 0.
  - Each cycle with DM_ready=1: data[index][counter] ← DM_out, counter++.
  - A cycle with DM_ready=0 mid-burst is a pause, not an abort.
  - On the 16th word: set valid[index] and tag[index]; go to IDLE, where the held load now hits.
- WR_ISSUE (1 cycle): drive DM_enable=1, DM_write=1, DM_address=latched address, DM_in=latched data; go to WR_DRAIN.
- WR_DRAIN: cpu_stall=1 for WRITE_HOLD cycles, counted down, then go to WR_DONE.
- WR_DONE (1 cycle): cpu_stall=0, which consumes the store; go to IDLE.
- The cache never allocates a line on a store miss.
- cpu_rdata=0 whenever it is not a valid load-hit output.
- DM_ready is ignored in every state except FILL.
- All DM_* outputs are registered from the state and the latched values, and are 0 outside FILL_REQ/WR_ISSUE.

## Timing
- Reset values: state IDLE, valid=0, counters 0, DM_enable=DM_read=DM_write=0, DM_address=0, DM_in=0, cpu_rdata=0.
- cpu_stall=1 while reset is asserted.
- Reset is asynchronous. Reset mid-FILL leaves the line invalid. Burst words that `dm` still strobes after reset release arrive in IDLE and are discarded.
- Load hit: zero stall cycles; back-to-back hits give one load per cycle.
- Load miss, with request in cycle 0:
  - cycle 1 is FILL_REQ;
  - the fill completes on the edge of the 16th DM_ready;
  - the next cycle is IDLE with a hit.
  - Total stall = 2 + (cycles until the 16th DM_ready).
- Store, with request in cycle 0:
  - cycle 1 is WR_ISSUE;
  - cycles 2..WRITE_HOLD+1 are WR_DRAIN;
  - cycle WRITE_HOLD+2 is WR_DONE with stall=0.
  - With the default WRITE_HOLD=3, the store is consumed at the end of cycle 5.
- Ordering: because of the drain, a load miss issued after a store sees the stored data in `dm`.

## Test plan
- Reset, then load 0x040 → stall, then FILL_REQ with DM_address=0x040, DM_enable=DM_read=1 for exactly one cycle. A 16-word burst of values 0x100+i → valid[1]=1, tag=0, cpu_rdata=0x100 with stall=0.
- After that fill, loads 0x044..0x07C on consecutive cycles → zero stalls, data 0x101..0x10F.
- Store 0x048 ← 0xDEADBEEF (hit) → DM_write pulse at cycle 1, stall low at cycle 5. A following load of 0x048 hits and returns 0xDEADBEEF.
- Store to 0x480 (miss) → one DM_write pulse; valid[2] stays 0; a following load of 0x480 misses and fills.
- Insert 3 DM_ready=0 gaps into the burst → all 16 words land at the correct offsets; stall extends by 3 cycles.
- Assert reset after the 5th burst word → state IDLE, valid[index]=0. The remaining 11 DM_ready strobes are ignored, and a reload of the same address refetches.
